// File: rtl/ping_scheduler_pkg.sv
// rtl/ping_scheduler_pkg.sv - shared types and constants for the ping scheduler
// Purpose: state enumeration, "no sensor" index, default timing values and
//          the modulo-3 index increment used by the selector and the FSM.
// Ports:   none (package).
package ping_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FIRE      = 2'd1,
    WAIT_ECHO = 2'd2,
    GUARD     = 2'd3
  } state_e;

  localparam logic [1:0] NONE_IDX        = 2'd3;
  localparam int         GUARD_CYC_DEF   = 500000;
  localparam int         TIMEOUT_CYC_DEF = 1900000;
  localparam int         TIMER_W         = 21;

  // Sensor indices run 0,1,2 and wrap back to 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/ping_scheduler_rr_select.sv
// rtl/ping_scheduler_rr_select.sv - 3-way round-robin sensor picker
// Purpose: pick the first enabled sensor at or after ptr, wrapping 0->1->2->0.
// Ports:   ptr_i  - index to start the search from (0..2)
//          mask_i - per-sensor enable
//          sel_o  - chosen index (NONE_IDX when mask_i is empty)
//          any_o  - at least one sensor enabled
module rr_select
  import ping_scheduler_pkg::*;
(
  input  logic [1:0] ptr_i,
  input  logic [2:0] mask_i,
  output logic [1:0] sel_o,
  output logic       any_o
);

  logic [1:0] cand1;
  logic [1:0] cand2;

  // Later assignments override earlier ones, so the candidate nearest to
  // ptr_i wins; the search start rotates, so no index is favoured.
  always_comb begin
    cand1 = next_idx(ptr_i);
    cand2 = next_idx(cand1);
    sel_o = NONE_IDX;
    if (mask_i[cand2]) sel_o = cand2;
    if (mask_i[cand1]) sel_o = cand1;
    if (mask_i[ptr_i]) sel_o = ptr_i;
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/ping_scheduler.sv
// rtl/ping_scheduler.sv - time-multiplexes three ultrasonic ping engines
// Purpose: fires one sensor at a time, waits for its echo or a timeout,
//          latches the distance, then enforces a guard gap before the next.
// Ports:   CLK, reset         - clock, synchronous active-high reset
//          EN_MASK            - per-sensor enable (0 side back, 1 side front, 2 front)
//          PING_DONE, DISTn   - measurement strobes and raw distances from engines
//          PING_START         - one-hot one-cycle trigger to the selected engine
//          DIST_OUTn, VALID   - latched distances and their update strobes
//          TIMEOUT            - sticky "last ping had no echo" per sensor
//          ACTIVE, BUSY       - current sensor index (3 = none), not-idle flag
module ping_scheduler
  import ping_scheduler_pkg::*;
#(
  parameter int GUARD_CYC   = GUARD_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [2:0] EN_MASK,
  input  logic [2:0] PING_DONE,
  input  logic [7:0] DIST0,
  input  logic [7:0] DIST1,
  input  logic [7:0] DIST2,
  output logic [2:0] PING_START,
  output logic [7:0] DIST_OUT0,
  output logic [7:0] DIST_OUT1,
  output logic [7:0] DIST_OUT2,
  output logic [2:0] VALID,
  output logic [2:0] TIMEOUT,
  output logic [1:0] ACTIVE,
  output logic       BUSY
);

  localparam logic [TIMER_W-1:0] TO_LAST    = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] GUARD_LAST = TIMER_W'(GUARD_CYC);

  state_e             state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         sel_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic [2:0]         ping_start_q;
  logic [2:0]         valid_q;
  logic [2:0]         timeout_q;
  logic [7:0]         dist_out0_q;
  logic [7:0]         dist_out1_q;
  logic [7:0]         dist_out2_q;
  logic [1:0]         active_q;
  logic               busy_q;

  logic [1:0] pick;
  logic       any_en;
  logic [2:0] sel_oh;
  logic       done_sel;
  logic [7:0] dist_sel;

  rr_select u_rr_select (
    .ptr_i  (ptr_q),
    .mask_i (EN_MASK),
    .sel_o  (pick),
    .any_o  (any_en)
  );

  // Saturating increment: the timer never wraps back to a small value.
  assign timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
  assign sel_oh  = 3'b001 << sel_q;

  // Only the selected engine's strobe and distance are looked at.
  always_comb begin
    done_sel = 1'b0;
    dist_sel = 8'h00;
    case (sel_q)
      2'd0:    begin done_sel = PING_DONE[0]; dist_sel = DIST0; end
      2'd1:    begin done_sel = PING_DONE[1]; dist_sel = DIST1; end
      2'd2:    begin done_sel = PING_DONE[2]; dist_sel = DIST2; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      sel_q        <= 2'd0;
      timer_q      <= '0;
      ping_start_q <= 3'b000;
      valid_q      <= 3'b000;
      timeout_q    <= 3'b000;
      dist_out0_q  <= 8'h00;
      dist_out1_q  <= 8'h00;
      dist_out2_q  <= 8'h00;
      active_q     <= NONE_IDX;
      busy_q       <= 1'b0;
    end else begin
      ping_start_q <= 3'b000;
      valid_q      <= 3'b000;
      case (state_q)
        IDLE: begin
          if (any_en) begin
            sel_q        <= pick;
            ping_start_q <= 3'b001 << pick;
            active_q     <= pick;
            busy_q       <= 1'b1;
            state_q      <= FIRE;
          end
        end
        FIRE: begin
          timer_q <= '0;
          state_q <= WAIT_ECHO;
        end
        WAIT_ECHO: begin
          // An echo arriving on the last timer count still counts as an echo.
          if (done_sel) begin
            case (sel_q)
              2'd0:    dist_out0_q <= dist_sel;
              2'd1:    dist_out1_q <= dist_sel;
              2'd2:    dist_out2_q <= dist_sel;
              default: ;
            endcase
            valid_q   <= sel_oh;
            timeout_q <= timeout_q & ~sel_oh;
            timer_q   <= '0;
            state_q   <= GUARD;
          end else if (timer_q == TO_LAST) begin
            timeout_q <= timeout_q | sel_oh;
            timer_q   <= '0;
            state_q   <= GUARD;
          end else begin
            timer_q <= timer_d;
          end
        end
        GUARD: begin
          if (timer_q == GUARD_LAST) begin
            ptr_q    <= next_idx(sel_q);
            active_q <= NONE_IDX;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PING_START = ping_start_q;
  assign VALID      = valid_q;
  assign TIMEOUT    = timeout_q;
  assign DIST_OUT0  = dist_out0_q;
  assign DIST_OUT1  = dist_out1_q;
  assign DIST_OUT2  = dist_out2_q;
  assign ACTIVE     = active_q;
  assign BUSY       = busy_q;

endmodule

// File: doc/ping_scheduler.md
PING_SCHEDULER -- requirements
Module: ping_scheduler

Interface
REQ-001 Parameter GUARD_CYC, default 500000, SHALL be the idle gap between consecutive pings (10 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 1900000, SHALL be the maximum echo wait per ping (38 ms at 50 MHz).
REQ-003 CLK  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 EN_MASK  in  3  SHALL be the per-sensor enable; bit0 = side back, bit1 = side front, bit2 = front.
REQ-006 PING_DONE  in  3  SHALL be the per-sensor measurement-complete strobes from the ping engines, each one cycle wide.
REQ-007 DIST0, DIST1, DIST2  in  8 each  SHALL be the raw distances from the ping engines.
REQ-008 PING_START  out  3  SHALL be the one-hot, one-cycle trigger to the selected ping engine.
REQ-009 DIST_OUT0, DIST_OUT1, DIST_OUT2  out  8 each  SHALL be the latched distance per sensor.
REQ-010 VALID  out  3  SHALL be the one-cycle strobe marking a DIST_OUTn update.
REQ-011 TIMEOUT  out  3  SHALL be the sticky per-sensor flag: the last ping got no echo.
REQ-012 ACTIVE  out  2  SHALL be the index of the sensor currently pinging (0 to 2); 3 when none.
REQ-013 BUSY  out  1  SHALL be high in every state except IDLE.

Function
REQ-014 The block SHALL fire exactly one sensor at a time, so sensors never overlap in time (no acoustic crosstalk).
REQ-015 The FSM SHALL have states IDLE, FIRE, WAIT_ECHO and GUARD.
REQ-016 IDLE SHALL move to FIRE when EN_MASK != 0; it SHALL select the first enabled index at or after ptr, round-robin 0 to 1 to 2 to 0.
REQ-017 FIRE SHALL last one cycle, assert PING_START[sel], load the timer to 0 and go to WAIT_ECHO.
REQ-018 WAIT_ECHO SHALL end on PING_DONE[sel]: latch DISTsel into DIST_OUTsel, pulse VALID[sel] the next cycle, clear TIMEOUT[sel] and go to GUARD.
REQ-019 WAIT_ECHO SHALL end on timeout when the timer reaches TIMEOUT_CYC-1: set TIMEOUT[sel], leave DIST_OUTsel unchanged, emit no VALID and go to GUARD.
REQ-020 If PING_DONE[sel] and timeout fall on the same cycle, PING_DONE SHALL win.
REQ-021 PING_DONE bits for non-selected sensors SHALL be ignored.
REQ-022 GUARD SHALL count GUARD_CYC cycles, then set ptr = sel+1 (mod 3) and return to IDLE.
REQ-023 PING_START-to-next-PING_START latency SHALL be: echo cycles + GUARD_CYC + 3 cycles (FIRE, GUARD exit, IDLE).
REQ-024 Clearing EN_MASK[sel] during WAIT_ECHO or GUARD SHALL NOT abort the current ping; the sensor is skipped from the next selection.
REQ-025 EN_MASK = 0 SHALL hold the FSM in IDLE with ACTIVE = 3.
REQ-026 The timer SHALL be 21 bits wide, saturate rather than wrap, and be shared by WAIT_ECHO and GUARD.
REQ-027 The selection logic SHALL be purely combinational from ptr and EN_MASK, with no priority bias.

Reset
REQ-028 reset SHALL set state = IDLE, ptr = 0, timer = 0, PING_START = 0, VALID = 0, TIMEOUT = 000, DIST_OUT0/1/2 = 8'h00, ACTIVE = 3 and BUSY = 0.
REQ-029 reset asserted mid-ping SHALL abandon the ping; a later PING_DONE from that ping SHALL be ignored because the FSM is in IDLE or FIRE.
REQ-030 The first PING_START after reset release SHALL occur no earlier than 2 cycles later (IDLE, then FIRE).

Structure
REQ-031 A shared package SHALL hold the state enumeration, the NONE index constant (2'd3) and the default GUARD_CYC/TIMEOUT_CYC values.
REQ-032 One sub-module, rr_select, SHALL implement the 3-way round-robin pick (ptr, mask to sel, any).
REQ-033 The top-level SHALL instantiate ping_scheduler between the three ping engines and their debounce stages; the existing ping-engine ports are unchanged.

Verification (bench uses GUARD_CYC = 8, TIMEOUT_CYC = 20)
REQ-034 EN_MASK = 111, all engines answer 5 cycles after start with DIST 10/20/30 -> PING_START sequence 001, 010, 100, 001; DIST_OUT = 10/20/30; three VALID pulses; PING_START spacing 5+8+3 = 16 cycles.
REQ-035 EN_MASK = 101, engine 2 never answers -> starts alternate 001/100; TIMEOUT[2] set after 20 cycles; DIST_OUT2 stays 00; no VALID[2].
REQ-036 PING_DONE[sel] in the same cycle as the timer reaching 19 -> VALID asserted; TIMEOUT bit stays 0.
REQ-037 PING_DONE[1] pulsed while sensor 0 is active -> ignored; DIST_OUT1 unchanged.
REQ-038 reset for 1 cycle during WAIT_ECHO, then a stale PING_DONE -> all outputs return to reset values; no VALID; next start is 001.
REQ-039 EN_MASK goes 111 to 000 mid-GUARD -> the current cycle completes; the FSM then parks in IDLE with BUSY = 0 and ACTIVE = 3.
